// File: rtl/string_pkg.sv
// ============================================================================
// Module   : string_pkg
// Brief    : Shared FSM/op encodings, default key codes and digit test.
// Revision : 1.0
// ============================================================================
`default_nettype none

package string_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEAD   = 2'd1,
        ST_REPLAY = 2'd2
    } state_e;

    // Resolved edit request handed from the key FSM to the buffer datapath
    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_APPEND = 3'd1,
        OP_DEL    = 3'd2,
        OP_CLR    = 3'd3,
        OP_COMMIT = 3'd4
    } op_e;

    localparam int         C_CHAR_W   = 7;
    localparam int         C_MAX_LEN  = 11;
    localparam logic [6:0] C_PAD      = 7'h20;
    localparam logic [6:0] C_K_ENTER  = 7'h0D;
    localparam logic [6:0] C_K_DEL    = 7'h08;
    localparam logic [6:0] C_K_CLR    = 7'h1B;
    localparam logic [6:0] C_K_DEAD   = 7'h2C;
    localparam logic [6:0] C_ENHE     = 7'h7E;
    localparam logic [6:0] C_KEY_N_LO = 7'h6E;
    localparam logic [6:0] C_KEY_N_UP = 7'h4E;

    function automatic logic is_digit(input logic [31:0] code);
        return (code >= 32'h30) && (code <= 32'h39);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dead_key_fsm.sv
// ============================================================================
// Module   : dead_key_fsm
// Brief    : Dead-key compose FSM; turns each accepted key into one edit op.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dead_key_fsm
    import string_pkg::*;
#(
    parameter int                CHAR_W  = C_CHAR_W,
    parameter logic [CHAR_W-1:0] K_ENTER = CHAR_W'(C_K_ENTER),
    parameter logic [CHAR_W-1:0] K_DEL   = CHAR_W'(C_K_DEL),
    parameter logic [CHAR_W-1:0] K_CLR   = CHAR_W'(C_K_CLR),
    parameter logic [CHAR_W-1:0] K_DEAD  = CHAR_W'(C_K_DEAD),
    parameter logic [CHAR_W-1:0] ENHE    = CHAR_W'(C_ENHE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] char_i,
    input  logic              new_i,
    input  logic              num_only_i,
    output logic              ready_o,
    output logic [2:0]        op_o,
    output logic [CHAR_W-1:0] code_o,
    output logic              op_nm_o,
    output logic              drop_err_o
);

    state_e            state_q, state_d;
    logic [CHAR_W-1:0] key_q, key_d;
    logic              nm_q, nm_d;
    op_e               op_d;

    logic [CHAR_W-1:0] w_key;
    logic              w_nm;
    logic              w_go;

    // REPLAY re-runs the latched key (and its mode) through the IDLE decode
    assign w_key = (state_q == ST_REPLAY) ? key_q : char_i;
    assign w_nm  = (state_q == ST_REPLAY) ? nm_q  : num_only_i;
    assign w_go  = (state_q == ST_REPLAY) || new_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            nm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            nm_q    <= nm_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        nm_d       = nm_q;
        op_d       = OP_NONE;
        code_o     = w_key;
        op_nm_o    = w_nm;
        drop_err_o = 1'b0;
        case (state_q)
            ST_IDLE, ST_REPLAY: begin
                drop_err_o = (state_q == ST_REPLAY) && new_i;
                if (state_q == ST_REPLAY) begin
                    state_d = ST_IDLE;
                end
                if (w_go) begin
                    if (w_key == K_ENTER) begin
                        op_d = OP_COMMIT;
                    end else if (w_key == K_DEL) begin
                        op_d = OP_DEL;
                    end else if (w_key == K_CLR) begin
                        op_d = OP_CLR;
                    end else if ((w_key == K_DEAD) && !w_nm) begin
                        state_d = ST_DEAD;
                    end else begin
                        // In digits-only mode the dead key is just a literal comma
                        op_d = OP_APPEND;
                    end
                end
            end
            ST_DEAD: begin
                if (new_i) begin
                    state_d = ST_IDLE;
                    if ((char_i == CHAR_W'(C_KEY_N_LO)) || (char_i == CHAR_W'(C_KEY_N_UP))) begin
                        op_d   = OP_APPEND;
                        code_o = ENHE;
                    end else if ((char_i != K_DEL) && (char_i != K_CLR)) begin
                        op_d    = OP_APPEND;
                        code_o  = K_DEAD;
                        key_d   = char_i;
                        nm_d    = num_only_i;
                        state_d = ST_REPLAY;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign op_o    = op_d;
    assign ready_o = (state_q != ST_REPLAY);

endmodule

`default_nettype wire

// File: rtl/string_entry.sv
// ============================================================================
// Module   : string_entry
// Brief    : Keyboard line editor with dead-key compose and commit register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module string_entry
    import string_pkg::*;
#(
    parameter int                CHAR_W  = C_CHAR_W,
    parameter int                MAX_LEN = C_MAX_LEN,
    parameter logic [CHAR_W-1:0] PAD     = CHAR_W'(C_PAD),
    parameter logic [CHAR_W-1:0] K_ENTER = CHAR_W'(C_K_ENTER),
    parameter logic [CHAR_W-1:0] K_DEL   = CHAR_W'(C_K_DEL),
    parameter logic [CHAR_W-1:0] K_CLR   = CHAR_W'(C_K_CLR),
    parameter logic [CHAR_W-1:0] K_DEAD  = CHAR_W'(C_K_DEAD),
    parameter logic [CHAR_W-1:0] ENHE    = CHAR_W'(C_ENHE)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHAR_W-1:0]             char_i,
    input  logic                          new_i,
    input  logic                          num_only_i,
    output logic                          ready_o,
    output logic [MAX_LEN*CHAR_W-1:0]     string_o,
    output logic [$clog2(MAX_LEN+1)-1:0]  length_o,
    output logic                          completeOut_o,
    output logic                          changeOut_o,
    output logic                          err_o
);

    localparam int               LEN_W  = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] C_FULL = LEN_W'(MAX_LEN);

    logic [CHAR_W-1:0] wbuf_q [MAX_LEN];
    logic [CHAR_W-1:0] wbuf_d [MAX_LEN];
    logic [CHAR_W-1:0] str_q  [MAX_LEN];
    logic [CHAR_W-1:0] str_d  [MAX_LEN];
    logic [LEN_W-1:0]  len_q, len_d;
    logic              complete_q, complete_d;
    logic              change_q, change_d;
    logic              err_q, err_d;

    logic [2:0]        w_op;
    logic [CHAR_W-1:0] w_code;
    logic              w_op_nm;
    logic              w_drop_err;
    logic              w_code_ok;

    dead_key_fsm #(
        .CHAR_W  (CHAR_W),
        .K_ENTER (K_ENTER),
        .K_DEL   (K_DEL),
        .K_CLR   (K_CLR),
        .K_DEAD  (K_DEAD),
        .ENHE    (ENHE)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .char_i     (char_i),
        .new_i      (new_i),
        .num_only_i (num_only_i),
        .ready_o    (ready_o),
        .op_o       (w_op),
        .code_o     (w_code),
        .op_nm_o    (w_op_nm),
        .drop_err_o (w_drop_err)
    );

    // The literal dead-key comma is the one non-digit allowed in digits-only mode
    assign w_code_ok = !w_op_nm || is_digit(32'(w_code)) || (w_code == K_DEAD);

    always_comb begin
        wbuf_d     = wbuf_q;
        str_d      = str_q;
        len_d      = len_q;
        complete_d = 1'b0;
        change_d   = 1'b0;
        err_d      = w_drop_err;
        case (w_op)
            OP_APPEND: begin
                if ((len_q < C_FULL) && w_code_ok) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (LEN_W'(i) == len_q) begin
                            wbuf_d[i] = w_code;
                        end
                    end
                    len_d    = len_q + LEN_W'(1);
                    change_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_DEL: begin
                if (len_q != '0) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (LEN_W'(i) == (len_q - LEN_W'(1))) begin
                            wbuf_d[i] = PAD;
                        end
                    end
                    len_d    = len_q - LEN_W'(1);
                    change_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_CLR: begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    wbuf_d[i] = PAD;
                end
                len_d    = '0;
                change_d = 1'b1;
            end
            OP_COMMIT: begin
                str_d      = wbuf_q;
                complete_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                wbuf_q[i] <= PAD;
                str_q[i]  <= PAD;
            end
            len_q      <= '0;
            complete_q <= 1'b0;
            change_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wbuf_q     <= wbuf_d;
            str_q      <= str_d;
            len_q      <= len_d;
            complete_q <= complete_d;
            change_q   <= change_d;
            err_q      <= err_d;
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign string_o[g*CHAR_W +: CHAR_W] = str_q[g];
    end

    assign length_o      = len_q;
    assign completeOut_o = complete_q;
    assign changeOut_o   = change_q;
    assign err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_string_entry.sv
// ============================================================================
// Module   : tb_string_entry
// Brief    : Randomised and directed bench for string_entry with a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_string_entry;

    localparam int CW = 7;
    localparam int ML = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] char_i;
    logic          new_i;
    logic          num_only_i;
    logic          ready_o;
    logic [ML*CW-1:0] string_o;
    logic [3:0]    length_o;
    logic          completeOut_o;
    logic          changeOut_o;
    logic          err_o;

    always #5 clk = ~clk;

    string_entry dut (
        .clk           (clk),
        .reset         (reset),
        .char_i        (char_i),
        .new_i         (new_i),
        .num_only_i    (num_only_i),
        .ready_o       (ready_o),
        .string_o      (string_o),
        .length_o      (length_o),
        .completeOut_o (completeOut_o),
        .changeOut_o   (changeOut_o),
        .err_o         (err_o)
    );

    // Behavioural model: the working buffer is a queue of characters
    logic [6:0] mq[$];
    logic [6:0] mstr [ML];
    bit         mdead, mrep, mrep_nm;
    logic [6:0] mrep_key;
    bit         ecomp, echg, eerr;
    bit         chk_en = 1'b0;
    int         checks = 0;
    int         failures = 0;

    task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit ok_code(input logic [6:0] c, input bit nm);
        return !nm || ((c >= 7'h30) && (c <= 7'h39)) || (c == 7'h2C);
    endfunction

    task automatic m_append(input logic [6:0] c, input bit nm);
        if ((mq.size() < ML) && ok_code(c, nm)) begin
            mq.push_back(c);
            echg = 1'b1;
        end else begin
            eerr = 1'b1;
        end
    endtask

    task automatic m_plain(input logic [6:0] k, input bit nm);
        if (k == 7'h0D) begin
            for (int i = 0; i < ML; i++) mstr[i] = (i < mq.size()) ? mq[i] : 7'h20;
            ecomp = 1'b1;
        end else if (k == 7'h08) begin
            if (mq.size() > 0) begin
                void'(mq.pop_back());
                echg = 1'b1;
            end else begin
                eerr = 1'b1;
            end
        end else if (k == 7'h1B) begin
            mq.delete();
            echg = 1'b1;
        end else if ((k == 7'h2C) && !nm) begin
            mdead = 1'b1;
        end else begin
            m_append(k, nm);
        end
    endtask

    task automatic m_step();
        ecomp = 1'b0;
        echg  = 1'b0;
        eerr  = 1'b0;
        if (reset) begin
            mq.delete();
            for (int i = 0; i < ML; i++) mstr[i] = 7'h20;
            mdead = 1'b0;
            mrep  = 1'b0;
        end else if (mrep) begin
            mrep = 1'b0;
            if (new_i) eerr = 1'b1;
            m_plain(mrep_key, mrep_nm);
        end else if (new_i) begin
            if (mdead) begin
                mdead = 1'b0;
                if ((char_i == 7'h6E) || (char_i == 7'h4E)) begin
                    m_append(7'h7E, num_only_i);
                end else if ((char_i != 7'h08) && (char_i != 7'h1B)) begin
                    m_append(7'h2C, num_only_i);
                    mrep     = 1'b1;
                    mrep_key = char_i;
                    mrep_nm  = num_only_i;
                end
            end else begin
                m_plain(char_i, num_only_i);
            end
        end
    endtask

    function automatic logic [ML*CW-1:0] m_pack();
        logic [ML*CW-1:0] r;
        for (int i = 0; i < ML; i++) r[i*CW +: CW] = mstr[i];
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("ready",    128'(ready_o),       128'(!mrep));
            cmp("length",   128'(length_o),      128'(mq.size()));
            cmp("string",   128'(string_o),      128'(m_pack()));
            cmp("complete", 128'(completeOut_o), 128'(ecomp));
            cmp("change",   128'(changeOut_o),   128'(echg));
            cmp("err",      128'(err_o),         128'(eerr));
        end
    end

    task automatic cyc(input logic [6:0] c, input logic n, input logic nm);
        char_i     = c;
        new_i      = n;
        num_only_i = nm;
        @(posedge clk);
        m_step();
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic key(input logic [6:0] c);
        cyc(c, 1'b1, 1'b0);
    endtask

    task automatic idle();
        cyc(7'h00, 1'b0, 1'b0);
    endtask

    logic [ML*CW-1:0] pad_all;
    int               r;
    logic [6:0]       rc;

    initial begin
        pad_all    = {ML{7'h20}};
        reset      = 1'b1;
        new_i      = 1'b0;
        char_i     = '0;
        num_only_i = 1'b0;
        @(negedge clk);
        idle();
        idle();
        reset = 1'b0;
        cmp("lit_reset_len",   128'(length_o), 128'(0));
        cmp("lit_reset_ready", 128'(ready_o),  128'(1));
        cmp("lit_reset_str",   128'(string_o), 128'(pad_all));

        // HOLA + ENTER
        key(7'h48); key(7'h4F); key(7'h4C); key(7'h41); key(7'h0D);
        cmp("lit_hola_len",  128'(length_o),      128'(4));
        cmp("lit_hola_cmp",  128'(completeOut_o), 128'(1));
        cmp("lit_hola_low",  128'(string_o[27:0]), 128'({7'h41, 7'h4C, 7'h4F, 7'h48}));
        cmp("lit_hola_pad",  128'(string_o[34:28]), 128'(7'h20));
        idle();
        cmp("lit_cmp_pulse", 128'(completeOut_o), 128'(0));

        // Full buffer, overflow, backspace
        key(7'h1B);
        for (int i = 0; i < ML; i++) key(7'(7'h61 + i));
        key(7'h58);
        cmp("lit_full_err", 128'(err_o),    128'(1));
        cmp("lit_full_len", 128'(length_o), 128'(11));
        key(7'h08);
        cmp("lit_del_len",  128'(length_o), 128'(10));
        key(7'h0D);
        cmp("lit_del_pos10", 128'(string_o[76:70]), 128'(7'h20));
        cmp("lit_del_pos9",  128'(string_o[69:63]), 128'(7'h6A));

        // Dead key compose to enhe
        key(7'h1B);
        key(7'h2C);
        cmp("lit_dead_nochg", 128'(changeOut_o), 128'(0));
        key(7'h6E);
        cmp("lit_enhe_len", 128'(length_o), 128'(1));
        key(7'h0D);
        cmp("lit_enhe_chr", 128'(string_o[6:0]), 128'(7'h7E));

        // Dead key + ordinary key: literal comma then replay, dropped strobe
        key(7'h1B);
        key(7'h2C);
        key(7'h61);
        cmp("lit_rep_ready", 128'(ready_o),  128'(0));
        cmp("lit_rep_len",   128'(length_o), 128'(1));
        key(7'h71);
        cmp("lit_rep_drop",  128'(err_o),    128'(1));
        cmp("lit_rep_len2",  128'(length_o), 128'(2));
        key(7'h0D);
        cmp("lit_rep_str",   128'(string_o[13:0]), 128'({7'h61, 7'h2C}));

        // Digits-only mode
        key(7'h1B);
        cyc(7'h35, 1'b1, 1'b1);
        cyc(7'h42, 1'b1, 1'b1);
        cmp("lit_nm_rej", 128'(err_o), 128'(1));
        cyc(7'h2C, 1'b1, 1'b1);
        cmp("lit_nm_comma", 128'(length_o), 128'(2));
        cyc(7'h6E, 1'b1, 1'b1);
        cmp("lit_nm_enhe", 128'(err_o), 128'(1));

        // Empty-buffer delete, clear, cancelled dead key
        key(7'h1B);
        key(7'h08);
        cmp("lit_del_empty", 128'(err_o), 128'(1));
        key(7'h1B);
        cmp("lit_clr_chg", 128'(changeOut_o), 128'(1));
        key(7'h2C);
        key(7'h08);
        cmp("lit_cancel_chg", 128'(changeOut_o), 128'(0));
        key(7'h7A);
        cmp("lit_cancel_idle", 128'(length_o), 128'(1));

        // Reset during REPLAY with a strobe present
        key(7'h0D);
        key(7'h2C);
        key(7'h62);
        reset = 1'b1;
        cyc(7'h63, 1'b1, 1'b0);
        reset = 1'b0;
        cmp("lit_rst_len",   128'(length_o), 128'(0));
        cmp("lit_rst_ready", 128'(ready_o),  128'(1));
        cmp("lit_rst_str",   128'(string_o), 128'(pad_all));

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 31);
            if (r < 2)       rc = 7'h0D;
            else if (r < 5)  rc = 7'h08;
            else if (r < 6)  rc = 7'h1B;
            else if (r < 10) rc = 7'h2C;
            else if (r < 12) rc = 7'h6E;
            else if (r < 13) rc = 7'h4E;
            else if (r < 21) rc = 7'(7'h30 + $urandom_range(0, 9));
            else             rc = 7'($urandom_range(33, 126));
            reset = ($urandom_range(0, 249) == 0);
            cyc(rc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
        end
        reset = 1'b0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/string_entry.md
# string_entry

Parametrised successor to the fixed 11-character string builder. Accepts one CHAR_W-bit key code per `new` strobe and edits a MAX_LEN-character working buffer (append, backspace, clear). Supports a dead-key compose for ñ and a digits-only mode. Commits the buffer to the display string on ENTER. Sits between the keyboard decoder and the POV column renderer; replaces the control/counter/shift/memory cluster with one block.

## Interface
- `CHAR_W`, 7: bits per character code.
- `MAX_LEN`, 11: working/committed string capacity in characters.
- `PAD`, 7'h20: fill code for unused positions.
- `K_ENTER`, 7'h0D: commit key.
- `K_DEL`, 7'h08: backspace key.
- `K_CLR`, 7'h1B: clear-buffer key.
- `K_DEAD`, 7'h2C: dead key (comma).
- `ENHE`, 7'h7E: code emitted for dead key + `n`/`N`.

Ports:
- `clk`  in  1  system clock, all logic rising-edge.
- `reset`  in  1  synchronous, active-high.
- `char`  in  CHAR_W  key code, valid when `new`=1.
- `new`  in  1  one-cycle key strobe; honoured only when `ready`=1.
- `num_only`  in  1  mode: printable keys other than `0`–`9` rejected.
- `ready`  out  1  block can accept a key this cycle.
- `string`  out  MAX_LEN*CHAR_W  committed string, char 0 in bits [CHAR_W-1:0].
- `length`  out  $clog2(MAX_LEN+1)  working-buffer character count.
- `completeOut`  out  1  one-cycle pulse on commit.
- `changeOut`  out  1  one-cycle pulse when working buffer changes.
- `err`  out  1  one-cycle pulse on rejected key.

## Operation
- Reset: working buffer and `string` all PAD, `length`=0, FSM=IDLE, `ready`=1, pulses 0.
- FSM states IDLE, DEAD, REPLAY.
- IDLE, accepted key:
  - K_ENTER: copy buffer (PAD-filled) to `string`, `completeOut`; buffer and `length` unchanged.
  - K_DEL: if `length`>0, position length-1 ← PAD, `length`−1, `changeOut`; else `err`.
  - K_CLR: all PAD, `length`=0, `changeOut` (even if already empty).
  - K_DEAD: go to DEAD; buffer unchanged.
  - Other: append at position `length`, `length`+1, `changeOut`.
- DEAD, accepted key:
  - `n`/`N`: append ENHE, back to IDLE.
  - K_DEL or K_CLR: cancel the dead key, back to IDLE, no edit.
  - Any other key: append K_DEAD literally, latch the key, go to REPLAY.
- REPLAY: `ready`=0; latched key processed exactly as in IDLE, then IDLE (one cycle).
- Rejections, each with one `err` pulse and no state change:
  - append while `length`=MAX_LEN (ENHE and literal K_DEAD included; if literal K_DEAD is rejected, the replayed key still runs);
  - `num_only`=1 and an append code outside 0x30–0x39 (K_DEAD itself accepted in num_only; it then appends literally, ENHE rejected);
  - `new`=1 while `ready`=0, key dropped.
- `num_only` sampled with the key; may change at any time.
- `string` changes only on commit or reset.

## Timing
- Key sampled at edge where `new`=1; buffer, `length`, `string`, pulses valid after that same edge (1-cycle latency).
- REPLAY adds one cycle: literal K_DEAD at edge N, replayed key effect at edge N+1; `ready` low during cycle N→N+1.
- Consecutive `new` strobes in back-to-back cycles supported in IDLE/DEAD.
- `reset` dominates `new` in the same cycle; reset mid-DEAD/REPLAY discards pending keys.
- Pulses never exceed one cycle; `changeOut` and `err` mutually exclusive per key.

## Structure
- Package `string_pkg`: FSM state enum, default key-code constants, `is_digit` function.
- Sub-module `dead_key_fsm` (IDLE/DEAD/REPLAY, latch, `ready`) emitting one resolved op per cycle to the buffer datapath in `string_entry`.

## Test plan
- Type `H`,`O`,`L`,`A`, ENTER → `length`=4, `string` low 28 bits = 41 4C 4F 48 (char0=`H`), rest 0x20, one `completeOut`.
- 11 appends then `X` → `length`=11, `err` once, buffer unchanged; K_DEL → `length`=10, position 10 = 0x20.
- `,` then `n` → ENHE appended, `length`+1; `,` then `a` → `,` and `a` appended on consecutive edges, `ready` low one cycle, `new` then dropped with `err`.
- `num_only`=1: `5` accepted, `B` → `err`, `,` `n` → `,` appended, then `err` for ENHE.
- K_DEL on empty → `err`; K_CLR → `changeOut`, `length`=0; `,` then K_DEL → no edit, state IDLE.
- `reset` asserted during REPLAY with `new`=1 → all outputs at reset values next cycle, `string` all 0x20.
